// File: rtl/key_tuning_ctrl.sv
// Debounced push-button controller producing the DDS frequency tuning word.
// Keys step the word up/down with auto-repeat on hold and min/max saturation.
module key_tuning_ctrl #(
  parameter int WORD_W          = 12,
  parameter int DEFAULT_WORD    = 8,
  parameter int MIN_WORD        = 4,
  parameter int MAX_WORD        = 4092,
  parameter int BASE_STEP       = 4,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int HOLD_CYCLES     = 25000000,
  parameter int REPEAT_CYCLES   = 5000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              freq_add,
  input  logic              freq_dec,
  input  logic              step_sel,
  output logic [WORD_W-1:0] freq_word,
  output logic [1:0]        step_idx,
  output logic              word_changed,
  output logic              at_limit
);

  localparam int AW    = WORD_W + 2;
  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int CNT_W = $clog2(((HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES) + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, REPEAT = 2'd2} state_t;

  function automatic logic is_limit(input logic [WORD_W-1:0] w);
    return (w == WORD_W'(MIN_WORD)) || (w == WORD_W'(MAX_WORD));
  endfunction

  // Key index 0 = add, 1 = dec, 2 = step select; all active-low.
  logic [2:0]      keys_s;
  logic [2:0]      sync1_q, sync2_q, db_q, press_q;
  logic [DB_W-1:0] db_cnt_q [3];

  state_t              state_q;
  logic                dir_q;
  logic [CNT_W-1:0]    hold_cnt_q;
  logic [WORD_W-1:0]   freq_word_q;
  logic [1:0]          step_idx_q;
  logic                word_changed_q;
  logic                at_limit_q;

  logic [AW-1:0]       step_s;
  logic [WORD_W-1:0]   word_up_s, word_dn_s, word_d;
  logic                step_dir_s, abort_s;

  assign keys_s = {step_sel, freq_dec, freq_add};

  // Synchronize each key and accept a level only after it has been stable long enough.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 3'b111;
      sync2_q <= 3'b111;
      db_q    <= 3'b111;
      press_q <= 3'b000;
      for (int k = 0; k < 3; k++) db_cnt_q[k] <= '0;
    end else begin
      sync1_q <= keys_s;
      sync2_q <= sync1_q;
      for (int k = 0; k < 3; k++) begin
        press_q[k] <= 1'b0;
        if (sync2_q[k] != db_q[k]) begin
          if (db_cnt_q[k] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            db_q[k]     <= sync2_q[k];
            db_cnt_q[k] <= '0;
            press_q[k]  <= ~sync2_q[k];
          end else begin
            db_cnt_q[k] <= db_cnt_q[k] + DB_W'(1);
          end
        end else begin
          db_cnt_q[k] <= '0;
        end
      end
    end
  end

  // Candidate next words in both directions, computed two bits wider so nothing wraps.
  always_comb begin
    step_s = AW'(BASE_STEP) << {step_idx_q, 1'b0};
    if (({2'b00, freq_word_q} + step_s) > AW'(MAX_WORD)) begin
      word_up_s = WORD_W'(MAX_WORD);
    end else begin
      word_up_s = WORD_W'({2'b00, freq_word_q} + step_s);
    end
    if ({2'b00, freq_word_q} < (AW'(MIN_WORD) + step_s)) begin
      word_dn_s = WORD_W'(MIN_WORD);
    end else begin
      word_dn_s = WORD_W'({2'b00, freq_word_q} - step_s);
    end
    step_dir_s = (state_q == IDLE) ? press_q[0] : dir_q;
    word_d     = step_dir_s ? word_up_s : word_dn_s;
    abort_s    = dir_q ? (db_q[0] | ~db_q[1]) : (db_q[1] | ~db_q[0]);
  end

  // Press/hold/repeat FSM together with the registered outputs it drives.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      dir_q          <= 1'b0;
      hold_cnt_q     <= '0;
      freq_word_q    <= WORD_W'(DEFAULT_WORD);
      step_idx_q     <= 2'd0;
      word_changed_q <= 1'b0;
      at_limit_q     <= is_limit(WORD_W'(DEFAULT_WORD));
    end else begin
      word_changed_q <= 1'b0;
      if (press_q[2]) begin
        step_idx_q <= step_idx_q + 2'd1;
      end else begin
        step_idx_q <= step_idx_q;
      end
      case (state_q)
        IDLE: begin
          hold_cnt_q <= '0;
          if (press_q[0] ^ press_q[1]) begin
            dir_q          <= press_q[0];
            freq_word_q    <= word_d;
            word_changed_q <= (word_d != freq_word_q);
            at_limit_q     <= is_limit(word_d);
            state_q        <= HOLD;
          end else begin
            state_q <= IDLE;
          end
        end
        HOLD, REPEAT: begin
          if (abort_s) begin
            state_q    <= IDLE;
            hold_cnt_q <= '0;
          end else if (((state_q == HOLD) && (hold_cnt_q == CNT_W'(HOLD_CYCLES - 1))) ||
                       ((state_q == REPEAT) && (hold_cnt_q == CNT_W'(REPEAT_CYCLES - 1)))) begin
            freq_word_q    <= word_d;
            word_changed_q <= (word_d != freq_word_q);
            at_limit_q     <= is_limit(word_d);
            hold_cnt_q     <= '0;
            state_q        <= REPEAT;
          end else begin
            hold_cnt_q <= hold_cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q    <= IDLE;
          hold_cnt_q <= '0;
        end
      endcase
    end
  end

  assign freq_word    = freq_word_q;
  assign step_idx     = step_idx_q;
  assign word_changed = word_changed_q;
  assign at_limit     = at_limit_q;

endmodule

// File: tb/tb_key_tuning_ctrl.sv
// Directed bench for key_tuning_ctrl; expected word updates are queued at stimulus
// time and popped by a monitor on every word_changed pulse.
module tb_key_tuning_ctrl;

  localparam int WORD_W = 12;

  logic              clk = 1'b0;
  logic              reset;
  logic              freq_add, freq_dec, step_sel;
  logic [WORD_W-1:0] freq_word;
  logic [1:0]        step_idx;
  logic              word_changed, at_limit;

  typedef struct packed {
    logic [WORD_W-1:0] word;
    logic              lim;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  key_tuning_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES(10),
    .REPEAT_CYCLES(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .freq_add(freq_add),
    .freq_dec(freq_dec),
    .step_sel(step_sel),
    .freq_word(freq_word),
    .step_idx(step_idx),
    .word_changed(word_changed),
    .at_limit(at_limit)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic push_exp(input int w, input bit l);
    exp_t e;
    e.word = w[WORD_W-1:0];
    e.lim  = l;
    exp_q.push_back(e);
  endtask

  // Monitor: every word_changed pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (reset && word_changed) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_pulse: got word %0d, expected no pulse", freq_word);
      end else begin
        e = exp_q.pop_front();
        check("sb_word", int'(freq_word), int'(e.word));
        check("sb_limit", int'(at_limit), int'(e.lim));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_key(input int k, input logic v);
    case (k)
      0:       freq_add = v;
      1:       freq_dec = v;
      default: step_sel = v;
    endcase
  endtask

  task automatic press(input int k);
    set_key(k, 1'b0);
    tick(8);
    set_key(k, 1'b1);
    tick(12);
  endtask

  task automatic drain(input string name);
    tick(4);
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(2);
  endtask

  initial begin
    reset    = 1'b0;
    freq_add = 1'b1;
    freq_dec = 1'b1;
    step_sel = 1'b1;
    tick(3);
    check("rst_word_in", int'(freq_word), 8);
    check("rst_pulse_in", int'(word_changed), 0);
    reset = 1'b1;
    tick(2);
    // Reset state after release
    check("rst_word", int'(freq_word), 8);
    check("rst_step", int'(step_idx), 0);
    check("rst_limit", int'(at_limit), 0);
    check("rst_pulse", int'(word_changed), 0);

    // Glitch rejection, then exact debounce latency
    freq_add = 1'b0;
    tick(2);
    freq_add = 1'b1;
    tick(8);
    check("glitch_word", int'(freq_word), 8);
    push_exp(12, 1'b0);
    freq_add = 1'b0;
    tick(6);
    check("latency_before", int'(freq_word), 8);
    tick(1);
    check("latency_at", int'(freq_word), 12);
    check("latency_pulse", int'(word_changed), 1);
    tick(1);
    freq_add = 1'b1;
    tick(12);
    drain("glitch_queue");

    // Decrement into and against the lower limit
    do_reset();
    push_exp(4, 1'b1);
    press(1);
    press(1);
    press(1);
    check("dec_word", int'(freq_word), 4);
    check("dec_limit", int'(at_limit), 1);
    drain("dec_queue");

    // Step size selection and wrap of step_idx
    do_reset();
    press(2);
    press(2);
    check("step_idx2", int'(step_idx), 2);
    push_exp(72, 1'b0);
    press(0);
    check("step64_word", int'(freq_word), 72);
    press(2);
    press(2);
    check("step_wrap", int'(step_idx), 0);
    check("step_word_kept", int'(freq_word), 72);
    drain("step_queue");

    // Hold then auto-repeat: 7 steps of 4 from 8
    do_reset();
    for (int i = 1; i <= 7; i++) push_exp(8 + 4 * i, 1'b0);
    freq_add = 1'b0;
    tick(27);
    freq_add = 1'b1;
    tick(15);
    check("repeat_word", int'(freq_word), 36);
    drain("repeat_queue");

    // Auto-repeat with step 256 saturating at MAX_WORD
    do_reset();
    press(2);
    press(2);
    press(2);
    check("sat_step_idx", int'(step_idx), 3);
    for (int i = 1; i <= 15; i++) push_exp(8 + 256 * i, 1'b0);
    push_exp(4092, 1'b1);
    freq_add = 1'b0;
    tick(80);
    check("sat_word", int'(freq_word), 4092);
    check("sat_limit", int'(at_limit), 1);
    check("sat_queue", exp_q.size(), 0);
    exp_q.delete();

    // Asynchronous reset while still repeating
    reset = 1'b0;
    #1;
    check("async_rst_word", int'(freq_word), 8);
    check("async_rst_step", int'(step_idx), 0);
    check("async_rst_limit", int'(at_limit), 0);
    check("async_rst_pulse", int'(word_changed), 0);
    freq_add = 1'b1;
    tick(2);
    reset = 1'b1;
    tick(12);
    check("post_rst_word", int'(freq_word), 8);

    // Simultaneous add+dec press is ignored, FSM remains able to act
    freq_add = 1'b0;
    freq_dec = 1'b0;
    tick(8);
    freq_add = 1'b1;
    freq_dec = 1'b1;
    tick(12);
    check("both_word", int'(freq_word), 8);
    push_exp(12, 1'b0);
    press(0);
    check("after_both_word", int'(freq_word), 12);
    drain("both_queue");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
